oled_screen_mux: RTL and testbench
==================================

// Module: oled_screen_mux
// PURPOSE
//   Parametrised, registered screen selector for the 96x64 RGB565 OLED path.
//   Picks one of NUM_SCREENS pixel sources by machine_state. Screen changes are
//   committed only at frame boundaries, so a frame never tears.
//   Optionally runs a left-to-right wipe between the old and new screen.
//   Sits between the per-state screen renderers and the OLED driver.
// PARAMETERS
//   NUM_SCREENS   11       number of screen inputs (indices 0..NUM_SCREENS-1)
//   SEL_W         4        width of machine_state / active_sel
//   VALID_MASK    11'h77B  bit i=1: screen i is populated; bit i=0: screen i shows BLANK_COLOUR
//   BLANK_COLOUR  16'h0000 pixel driven for unpopulated/out-of-range screens and pixels
//   WIPE_STEP     16       wipe advance in columns per frame (1..96)
// PORTS
//   clk           in   1                clock
//   reset         in   1                synchronous, active-high reset
//   machine_state in   SEL_W            requested screen index
//   screen_data   in   NUM_SCREENS*16   screen i pixel at bits [16*i+15:16*i]
//   pixel_index   in   13               driver pixel address, 0..6143 (row*96+col)
//   frame_begin   in   1                1-cycle pulse at start of each frame
//   oled_data     out  16               registered pixel to OLED driver
//   active_sel    out  SEL_W            screen currently committed (old screen during a wipe)
//   switching     out  1                high while a change is pending or a wipe is running
// BEHAVIOUR
//   Reset: oled_data=16'h0000, active_sel=0, state=SHOW, boundary=0, target=0, switching=0.
//   Latency: oled_data in cycle t+1 reflects pixel_index/screen_data in cycle t (1 register).
//   Pixel lookup: pix(s) = BLANK_COLOUR if s>=NUM_SCREENS or VALID_MASK[s]==0, else slice s.
//     pixel_index>=6144 -> BLANK_COLOUR regardless of state.
//   col = pixel_index % 96, combinational.
//   States: SHOW, WIPE. The state register changes only on cycles with frame_begin=1.
//   SHOW: oled_data <= pix(active_sel).
//     On frame_begin with machine_state != active_sel:
//       no wipe -> active_sel <= machine_state (hard cut); the new frame is the new screen.
//       wipe    -> target <= machine_state, boundary <= WIPE_STEP, go to WIPE.
//   WIPE: oled_data <= pix(target) if col < boundary, else pix(active_sel).
//     On frame_begin:
//       boundary+WIPE_STEP >= 96 -> active_sel <= target, boundary <= 0, go to SHOW.
//       otherwise                -> boundary += WIPE_STEP.
//     machine_state changes during a wipe are ignored until the wipe completes.
//     The next change is then taken at the following frame_begin.
//     Example, WIPE_STEP=16: 5 wipe frames (boundary 16,32,48,64,80), then the new screen.
//   Changes of machine_state between frame_begin pulses never affect the frame in progress.
//     A change that reverts before the next frame_begin causes no transition.
//   switching = (machine_state != active_sel) | (state==WIPE), combinational.
//   Switching to an unpopulated screen is legal and displays BLANK_COLOUR.
//   Reset mid-wipe: all registers return to reset values on the next edge.
//   Reset has priority over frame_begin.
//   boundary is 7 bits. The comparison uses boundary+WIPE_STEP widened to 8 bits.
//   No overflow for WIPE_STEP<=96.
// CONFIGURATION
//   OLED_MUX_WIPE_EN defined: the WIPE state, target and boundary registers exist; the wipe
//     is as described above.
//   OLED_MUX_WIPE_EN undefined: only SHOW exists; all changes are hard cuts at frame_begin.
//     WIPE_STEP is unused. switching = (machine_state != active_sel).
// TESTING
//   T1 reset: assert reset 2 cycles -> oled_data=0000, active_sel=0, switching=0.
//   T2 hard cut (macro off), screen0=F800, screen3=07E0:
//     machine_state 0->3 mid-frame -> screen0 holds until frame_begin.
//     Cycle after frame_begin: active_sel=3; next pixel outputs 07E0.
//   T3 blank: machine_state=2 (VALID_MASK bit2=0) committed -> every pixel 0000.
//     pixel_index=6200 on any screen -> 0000.
//   T4 revert: machine_state 0->5->0 within one frame -> no commit, active_sel=0.
//     switching high only while machine_state=5.
//   T5 wipe (macro on, WIPE_STEP=16), 0->4:
//     first wipe frame: col 15 = screen4, col 16 = screen0.
//     after 5 wipe frames: active_sel=4, switching=0.
//     change to 6 mid-wipe is ignored until the wipe completes.
//   T6 reset mid-wipe (boundary=48) -> state SHOW, active_sel=0, oled_data=0000 next cycle.

Source files
------------

// File: rtl/oled_screen_mux.sv
// Registered screen selector for the 96x64 RGB565 OLED path; screen changes commit only at frame_begin.
// Define OLED_MUX_WIPE_EN to replace hard cuts with a left-to-right wipe of WIPE_STEP columns per frame.
module oled_screen_mux #(
  parameter int                     NUM_SCREENS  = 11,
  parameter int                     SEL_W        = 4,
  parameter logic [NUM_SCREENS-1:0] VALID_MASK   = 11'h77B,
  parameter logic [15:0]            BLANK_COLOUR = 16'h0000,
  parameter int                     WIPE_STEP    = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [SEL_W-1:0]          machine_state,
  input  logic [NUM_SCREENS*16-1:0] screen_data,
  input  logic [12:0]               pixel_index,
  input  logic                      frame_begin,
  output logic [15:0]               oled_data,
  output logic [SEL_W-1:0]          active_sel,
  output logic                      switching,
  output logic                      state_dbg_o
);

  // Handshake: none. frame_begin is a 1-cycle strobe; pixel_index/screen_data are sampled every cycle.

  if (WIPE_STEP < 1 || WIPE_STEP > 96) begin : g_bad_step
    $error("WIPE_STEP must be in 1..96");
  end

  logic [15:0]      oled_data_q, oled_data_d;
  logic [SEL_W-1:0] active_sel_q;
  logic             in_range;

  function automatic logic [15:0] pix(input logic [SEL_W-1:0] s,
                                      input logic [NUM_SCREENS*16-1:0] data);
    logic [15:0] p;
    p = BLANK_COLOUR;
    for (int i = 0; i < NUM_SCREENS; i++) begin
      if (int'(s) == i && VALID_MASK[i]) p = data[16*i +: 16];
    end
    return p;
  endfunction

  assign in_range = (pixel_index < 13'd6144);

`ifdef OLED_MUX_WIPE_EN
  typedef enum logic {SHOW = 1'b0, WIPE = 1'b1} state_t;

  state_t           state_q;
  logic [SEL_W-1:0] target_q;
  logic [6:0]       boundary_q;
  logic [6:0]       col;
  logic [7:0]       boundary_next;

  assign col           = 7'(pixel_index % 13'd96);
  assign boundary_next = {1'b0, boundary_q} + 8'(WIPE_STEP);

  always_comb begin
    oled_data_d = BLANK_COLOUR;
    if (in_range) begin
      // Columns left of the boundary already show the incoming screen.
      if (state_q == WIPE && col < boundary_q) oled_data_d = pix(target_q, screen_data);
      else                                     oled_data_d = pix(active_sel_q, screen_data);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      oled_data_q  <= 16'h0000;
      active_sel_q <= '0;
      target_q     <= '0;
      boundary_q   <= '0;
      state_q      <= SHOW;
    end else begin
      oled_data_q <= oled_data_d;
      if (frame_begin) begin
        case (state_q)
          SHOW: begin
            if (machine_state != active_sel_q) begin
              target_q   <= machine_state;
              boundary_q <= 7'(WIPE_STEP);
              state_q    <= WIPE;
            end
          end
          WIPE: begin
            if (boundary_next >= 8'd96) begin
              active_sel_q <= target_q;
              boundary_q   <= '0;
              state_q      <= SHOW;
            end else begin
              boundary_q <= boundary_next[6:0];
            end
          end
          default: state_q <= SHOW;
        endcase
      end
    end
  end

  assign switching   = (machine_state != active_sel_q) | (state_q == WIPE);
  assign state_dbg_o = (state_q == WIPE);
`else
  always_comb begin
    oled_data_d = BLANK_COLOUR;
    if (in_range) oled_data_d = pix(active_sel_q, screen_data);
  end

  // Only the SHOW state exists: every change is a hard cut at the frame boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      oled_data_q  <= 16'h0000;
      active_sel_q <= '0;
    end else begin
      oled_data_q <= oled_data_d;
      if (frame_begin && machine_state != active_sel_q) active_sel_q <= machine_state;
    end
  end

  assign switching   = (machine_state != active_sel_q);
  assign state_dbg_o = 1'b0;
`endif

  assign oled_data  = oled_data_q;
  assign active_sel = active_sel_q;

endmodule

// File: tb/tb_oled_screen_mux.sv
// Directed bench for oled_screen_mux: reset, hard cut / wipe, blank screens, revert and reset mid-wipe.
// Wipe scenarios are compiled in when OLED_MUX_WIPE_EN is defined.
module tb_oled_screen_mux;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   machine_state;
  logic [175:0] screen_data;
  logic [12:0]  pixel_index;
  logic         frame_begin;
  logic [15:0]  oled_data;
  logic [3:0]   active_sel;
  logic         switching;
  logic         state_dbg;

  int n_cmp  = 0;
  int n_fail = 0;

`ifdef OLED_MUX_WIPE_EN
  localparam int COMMIT_FRAMES = 6;
`else
  localparam int COMMIT_FRAMES = 1;
`endif

  oled_screen_mux dut (
    .clk          (clk),
    .reset        (reset),
    .machine_state(machine_state),
    .screen_data  (screen_data),
    .pixel_index  (pixel_index),
    .frame_begin  (frame_begin),
    .oled_data    (oled_data),
    .active_sel   (active_sel),
    .switching    (switching),
    .state_dbg_o  (state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_fb();
    frame_begin = 1'b1;
    step();
    frame_begin = 1'b0;
  endtask

  task automatic commit(input logic [3:0] s);
    machine_state = s;
    repeat (COMMIT_FRAMES) pulse_fb();
  endtask

  task automatic test_reset();
    reset = 1'b1; machine_state = 4'd0; frame_begin = 1'b0; pixel_index = 13'd0;
    step(); step();
    n_cmp++; if (oled_data !== 16'h0000) begin n_fail++; $display("FAIL reset_oled: got %h want 0000", oled_data); end
    n_cmp++; if (active_sel !== 4'd0) begin n_fail++; $display("FAIL reset_sel: got %0d want 0", active_sel); end
    n_cmp++; if (switching !== 1'b0) begin n_fail++; $display("FAIL reset_switching: got %b want 0", switching); end
    n_cmp++; if (state_dbg !== 1'b0) begin n_fail++; $display("FAIL reset_state: got %b want 0", state_dbg); end
    machine_state = 4'd3; frame_begin = 1'b1;
    step();
    n_cmp++; if (active_sel !== 4'd0) begin n_fail++; $display("FAIL reset_priority: got %0d want 0", active_sel); end
    reset = 1'b0; frame_begin = 1'b0; machine_state = 4'd0;
    step();
  endtask

`ifndef OLED_MUX_WIPE_EN
  task automatic test_hard_cut();
    pixel_index = 13'd5;
    step();
    n_cmp++; if (oled_data !== 16'hF800) begin n_fail++; $display("FAIL cut_initial: got %h want F800", oled_data); end
    machine_state = 4'd3; pixel_index = 13'd10;
    step();
    n_cmp++; if (oled_data !== 16'hF800) begin n_fail++; $display("FAIL cut_hold: got %h want F800", oled_data); end
    n_cmp++; if (active_sel !== 4'd0) begin n_fail++; $display("FAIL cut_hold_sel: got %0d want 0", active_sel); end
    n_cmp++; if (switching !== 1'b1) begin n_fail++; $display("FAIL cut_pending: got %b want 1", switching); end
    pulse_fb();
    n_cmp++; if (active_sel !== 4'd3) begin n_fail++; $display("FAIL cut_commit: got %0d want 3", active_sel); end
    n_cmp++; if (oled_data !== 16'hF800) begin n_fail++; $display("FAIL cut_boundary_pix: got %h want F800", oled_data); end
    step();
    n_cmp++; if (oled_data !== 16'h07E0) begin n_fail++; $display("FAIL cut_new_pix: got %h want 07E0", oled_data); end
    n_cmp++; if (switching !== 1'b0) begin n_fail++; $display("FAIL cut_done: got %b want 0", switching); end
  endtask
`endif

  task automatic test_blank();
    logic [12:0] idx [4];
    idx[0] = 13'd0; idx[1] = 13'd95; idx[2] = 13'd3000; idx[3] = 13'd6143;
    commit(4'd2);
    n_cmp++; if (active_sel !== 4'd2) begin n_fail++; $display("FAIL blank_sel: got %0d want 2", active_sel); end
    for (int i = 0; i < 4; i++) begin
      pixel_index = idx[i];
      step();
      n_cmp++; if (oled_data !== 16'h0000) begin n_fail++; $display("FAIL blank_pix%0d: got %h want 0000", i, oled_data); end
    end
    commit(4'd7);
    pixel_index = 13'd100;
    step();
    n_cmp++; if (oled_data !== 16'h0000) begin n_fail++; $display("FAIL blank_mask7: got %h want 0000", oled_data); end
    commit(4'd12);
    step();
    n_cmp++; if (active_sel !== 4'd12) begin n_fail++; $display("FAIL blank_oor_sel: got %0d want 12", active_sel); end
    n_cmp++; if (oled_data !== 16'h0000) begin n_fail++; $display("FAIL blank_oor_pix: got %h want 0000", oled_data); end
  endtask

  task automatic test_back_to_back();
    logic [12:0] idx [5];
    logic [15:0] exp [5];
    idx[0] = 13'd6143; exp[0] = 16'h07E0;
    idx[1] = 13'd6144; exp[1] = 16'h0000;
    idx[2] = 13'd6200; exp[2] = 16'h0000;
    idx[3] = 13'd0;    exp[3] = 16'h07E0;
    idx[4] = 13'd8191; exp[4] = 16'h0000;
    commit(4'd3);
    for (int i = 0; i < 5; i++) begin
      pixel_index = idx[i];
      step();
      n_cmp++; if (oled_data !== exp[i]) begin n_fail++; $display("FAIL b2b_pix%0d: got %h want %h", i, oled_data, exp[i]); end
    end
  endtask

  task automatic test_revert();
    commit(4'd0);
    pixel_index = 13'd0;
    machine_state = 4'd5;
    step();
    n_cmp++; if (switching !== 1'b1) begin n_fail++; $display("FAIL revert_pending: got %b want 1", switching); end
    machine_state = 4'd0;
    step();
    n_cmp++; if (switching !== 1'b0) begin n_fail++; $display("FAIL revert_cleared: got %b want 0", switching); end
    pulse_fb();
    n_cmp++; if (active_sel !== 4'd0) begin n_fail++; $display("FAIL revert_sel: got %0d want 0", active_sel); end
    n_cmp++; if (state_dbg !== 1'b0) begin n_fail++; $display("FAIL revert_state: got %b want 0", state_dbg); end
    step();
    n_cmp++; if (oled_data !== 16'hF800) begin n_fail++; $display("FAIL revert_pix: got %h want F800", oled_data); end
  endtask

`ifdef OLED_MUX_WIPE_EN
  task automatic test_wipe();
    machine_state = 4'd4;
    pulse_fb();
    n_cmp++; if (state_dbg !== 1'b1) begin n_fail++; $display("FAIL wipe_enter: got %b want 1", state_dbg); end
    n_cmp++; if (active_sel !== 4'd0) begin n_fail++; $display("FAIL wipe_old_sel: got %0d want 0", active_sel); end
    pixel_index = 13'd15; step();
    n_cmp++; if (oled_data !== 16'h001F) begin n_fail++; $display("FAIL wipe_col15: got %h want 001F", oled_data); end
    pixel_index = 13'd16; step();
    n_cmp++; if (oled_data !== 16'hF800) begin n_fail++; $display("FAIL wipe_col16: got %h want F800", oled_data); end
    pixel_index = 13'd111; step();
    n_cmp++; if (oled_data !== 16'h001F) begin n_fail++; $display("FAIL wipe_row1_col15: got %h want 001F", oled_data); end
    machine_state = 4'd6;
    repeat (4) pulse_fb();
    pixel_index = 13'd79; step();
    n_cmp++; if (oled_data !== 16'h001F) begin n_fail++; $display("FAIL wipe_col79: got %h want 001F", oled_data); end
    pixel_index = 13'd80; step();
    n_cmp++; if (oled_data !== 16'hF800) begin n_fail++; $display("FAIL wipe_col80: got %h want F800", oled_data); end
    n_cmp++; if (switching !== 1'b1) begin n_fail++; $display("FAIL wipe_switching: got %b want 1", switching); end
    pulse_fb();
    n_cmp++; if (active_sel !== 4'd4) begin n_fail++; $display("FAIL wipe_commit: got %0d want 4", active_sel); end
    n_cmp++; if (state_dbg !== 1'b0) begin n_fail++; $display("FAIL wipe_exit: got %b want 0", state_dbg); end
    pixel_index = 13'd95; step();
    n_cmp++; if (oled_data !== 16'h001F) begin n_fail++; $display("FAIL wipe_full_new: got %h want 001F", oled_data); end
    pulse_fb();
    n_cmp++; if (state_dbg !== 1'b1) begin n_fail++; $display("FAIL wipe_next_enter: got %b want 1", state_dbg); end
    repeat (5) pulse_fb();
    n_cmp++; if (active_sel !== 4'd6) begin n_fail++; $display("FAIL wipe_next_commit: got %0d want 6", active_sel); end
    n_cmp++; if (switching !== 1'b0) begin n_fail++; $display("FAIL wipe_next_done: got %b want 0", switching); end
  endtask

  task automatic test_reset_mid_wipe();
    machine_state = 4'd0;
    repeat (3) pulse_fb();
    n_cmp++; if (state_dbg !== 1'b1) begin n_fail++; $display("FAIL midwipe_state: got %b want 1", state_dbg); end
    pixel_index = 13'd40; step();
    n_cmp++; if (oled_data !== 16'hF800) begin n_fail++; $display("FAIL midwipe_col40: got %h want F800", oled_data); end
    pixel_index = 13'd50; step();
    n_cmp++; if (oled_data !== 16'h6666) begin n_fail++; $display("FAIL midwipe_col50: got %h want 6666", oled_data); end
    reset = 1'b1;
    step();
    n_cmp++; if (state_dbg !== 1'b0) begin n_fail++; $display("FAIL midwipe_rst_state: got %b want 0", state_dbg); end
    n_cmp++; if (active_sel !== 4'd0) begin n_fail++; $display("FAIL midwipe_rst_sel: got %0d want 0", active_sel); end
    n_cmp++; if (oled_data !== 16'h0000) begin n_fail++; $display("FAIL midwipe_rst_oled: got %h want 0000", oled_data); end
    reset = 1'b0;
    step();
  endtask
`endif

  initial begin
    screen_data = {16'hAAAA, 16'h9999, 16'h8888, 16'h7777, 16'h6666, 16'h5555,
                   16'h001F, 16'h07E0, 16'h2222, 16'h1111, 16'hF800};
    test_reset();
`ifndef OLED_MUX_WIPE_EN
    test_hard_cut();
`endif
    test_blank();
    test_back_to_back();
    test_revert();
`ifdef OLED_MUX_WIPE_EN
    test_wipe();
    test_reset_mid_wipe();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
